// File: rtl/program_loader.sv
// Framed byte-stream loader: 4-byte header (addr, len), payload written to memory, then the
// load address into the reset vector. Optional checksum byte after payload: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [15:0] VEC_ADDR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_VLO  = 3'd4;
  localparam logic [2:0] ST_VHI  = 3'd5;
  localparam logic [2:0] ST_FIN  = 3'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_POST = ST_CSUM;
`else
  localparam logic [2:0] ST_POST = ST_VLO;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        wr_q, wr_d;
  logic [15:0] maddr_q, maddr_d;
  logic [7:0]  mdata_q, mdata_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  lenlo_q, lenlo_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif
  logic        xfer;

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
  assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
`endif
  assign busy        = (state_q != ST_IDLE);
  assign cpu_hold    = busy;
  assign done        = done_q;
  assign error       = error_q;
  assign mem_write   = wr_q;
  assign mem_address = maddr_q;
  assign mem_data    = mdata_q;
  assign xfer        = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    done_d  = done_q;
    error_d = error_q;
    wr_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    addr_d  = addr_q;
    lenlo_d = lenlo_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          hcnt_d  = 2'd0;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      ST_HDR: begin
        if (xfer) begin
          hcnt_d = hcnt_q + 2'd1;
          case (hcnt_q)
            2'd0: addr_d[7:0]  = in_data;
            2'd1: addr_d[15:8] = in_data;
            2'd2: lenlo_d      = in_data;
            default: begin
              cnt_d   = {in_data, lenlo_q};
              ptr_d   = addr_q;
              state_d = ({in_data, lenlo_q} == 16'h0000) ? ST_POST : ST_DATA;
            end
          endcase
        end
      end
      ST_DATA: begin
        if (xfer) begin
          wr_d    = 1'b1;
          maddr_d = ptr_q;
          mdata_d = in_data;
          ptr_d   = ptr_q + 16'd1;
          cnt_d   = cnt_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          if (cnt_q == 16'd1) state_d = ST_POST;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = ST_VLO;
          end else begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end
      end
`endif
      ST_VLO: begin
        wr_d    = 1'b1;
        maddr_d = VEC_ADDR;
        mdata_d = addr_q[7:0];
        state_d = ST_VHI;
      end
      ST_VHI: begin
        wr_d    = 1'b1;
        maddr_d = VEC_ADDR + 16'd1;
        mdata_d = addr_q[15:8];
        state_d = ST_FIN;
      end
      // FIN keeps the bus held while the high vector byte is being written.
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
      done_d  = 1'b0;
      wr_d    = 1'b0;
      maddr_d = maddr_q;
      mdata_d = mdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= 2'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      wr_q    <= 1'b0;
      maddr_q <= 16'h0000;
      mdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
      error_q <= error_d;
      wr_q    <= wr_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  // Header/payload bookkeeping is always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    lenlo_q <= lenlo_d;
    ptr_q   <= ptr_d;
    cnt_q   <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
    sum_q   <= sum_d;
`endif
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized bench for program_loader; follows LOADER_CHECKSUM_EN like the design.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mem_address;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [55:0] wq[$];
  logic [7:0]  tbmem [logic [15:0]];

  program_loader #(.VEC_ADDR(16'hFFFC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write(mem_write),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write) begin
      wq.push_back({cyc[31:0], mem_address, mem_data});
      tbmem[mem_address] = mem_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; acc is the count of rising edges after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int acc);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_flags", {busy, cpu_hold, in_ready, done, error}, 5'b11100);
  endtask

  task automatic run_image(input logic [15:0] addr, input logic [7:0] pl[$],
                           input bit gaps, input bit bad_csum);
    logic [55:0] exp[$];
    logic [15:0] len;
    logic [7:0]  csum;
    int acc;
    int t_last;
    len  = 16'(pl.size());
    csum = 8'h00;
    wq.delete();
    tbmem.delete();
    do_start();
    send_byte(addr[7:0], gaps, acc);
    send_byte(addr[15:8], gaps, acc);
    send_byte(len[7:0], gaps, acc);
    send_byte(len[15:8], gaps, acc);
    t_last = acc;
    foreach (pl[k]) begin
      send_byte(pl[k], gaps, acc);
      exp.push_back({acc[31:0], 16'(addr + 16'(k)), pl[k]});
      csum = csum + pl[k];
      t_last = acc;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? csum + 8'h01 : csum, gaps, acc);
    t_last = acc;
`endif
    if (bad_csum) begin
      @(negedge clk);
      chk("badcsum_flags", {busy, cpu_hold, in_ready, done, error}, 5'b00001);
      repeat (3) @(negedge clk);
      chk("badcsum_nwrites", 64'(wq.size()), 64'(exp.size()));
    end else begin
      exp.push_back({32'(t_last + 1), 16'hFFFC, addr[7:0]});
      exp.push_back({32'(t_last + 2), 16'hFFFD, addr[15:8]});
      @(negedge clk);
      @(negedge clk);
      chk("busy_during_vec", {busy, cpu_hold, done}, 3'b110);
      @(negedge clk);
      chk("done_flags", {busy, cpu_hold, in_ready, done, error}, 5'b00010);
      @(negedge clk);
      chk("nwrites", 64'(wq.size()), 64'(exp.size()));
      chk("vec_lo_mem", 64'(tbmem[16'hFFFC]), 64'(addr[7:0]));
      chk("vec_hi_mem", 64'(tbmem[16'hFFFD]), 64'(addr[15:8]));
    end
    foreach (exp[i]) begin
      if (i < wq.size()) chk($sformatf("write%0d", i), 64'(wq[i]), 64'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] img[$];
    logic [15:0] ra;
    int acc;
    int n0;

    #2;
    chk("reset_outputs", {mem_address, mem_data, mem_write, in_ready, busy, cpu_hold, done, error}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {mem_address, mem_data, mem_write, in_ready, busy, cpu_hold, done, error}, 64'd0);

    img = '{8'hA9, 8'h05, 8'h00};
    run_image(16'h8000, img, 1'b0, 1'b0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_noeffect", {busy, done, error}, 3'b010);

    run_image(16'h8000, img, 1'b1, 1'b0);

    img = '{8'h11, 8'h22, 8'h33};
    run_image(16'hFFFE, img, 1'b0, 1'b0);
    chk("wrap_mem0", 64'(tbmem[16'h0000]), 64'h33);

    run_image(16'hFFFB, img, 1'b0, 1'b0);
    chk("overlap_fffb", 64'(tbmem[16'hFFFB]), 64'h11);

    img.delete();
    run_image(16'h9000, img, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      img.delete();
      ra = 16'($urandom);
      n0 = $urandom_range(1, 12);
      for (int k = 0; k < n0; k++) img.push_back(8'($urandom));
      run_image(ra, img, 1'b1, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    img = '{8'hA9, 8'h05, 8'h00};
    run_image(16'h8000, img, 1'b0, 1'b1);
`endif

    // Abort after two payload bytes.
    wq.delete();
    do_start();
    send_byte(8'h00, 1'b0, acc);
    send_byte(8'h80, 1'b0, acc);
    send_byte(8'h03, 1'b0, acc);
    send_byte(8'h00, 1'b0, acc);
    send_byte(8'hA9, 1'b0, acc);
    send_byte(8'h05, 1'b0, acc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_flags", {busy, cpu_hold, in_ready, done, error}, 5'b00001);
    repeat (4) @(negedge clk);
    chk("abort_nwrites", 64'(wq.size()), 64'd2);

    do_start();
    send_byte(8'h00, 1'b0, acc);
    send_byte(8'h80, 1'b0, acc);
    send_byte(8'h03, 1'b0, acc);
    send_byte(8'h00, 1'b0, acc);
    send_byte(8'h77, 1'b0, acc);
    chk("pre_reset_addr", 64'(mem_address), 64'h8000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {mem_address, mem_data, mem_write, in_ready, busy, cpu_hold, done, error}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {mem_write, busy, done, error}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
